cast_rr_scheduler: RTL

CAST_RR_SCHEDULER -- requirements
Module: cast_rr_scheduler

---
 rtl/cast_rr_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/cast_rr_scheduler.sv
// cast_rr_scheduler
//   Round-robin arbiter that picks one of N_CH requesting channels per cycle
//   and casts the granted signed fixed-point word from DIN_WIDTH/DIN_POINT
//   to DOUT_WIDTH/DOUT_POINT. Fractional bits are floored or zero-padded.
//   Integer overflow saturates and is flagged on 'warning'. The result is
//   registered, so latency is one cycle.
//
// Optional feature (macro CAST_SAT_CNT_EN):
//   When defined, each channel has a sticky-at-max saturation counter that
//   is exported on sat_cnt and cleared by sat_clr. When undefined, sat_cnt
//   is tied to 0 and sat_clr is ignored.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   din        : N_CH packed input words, channel i at [i*DIN_WIDTH +: DIN_WIDTH]
//   din_valid  : per-channel request
//   din_ready  : per-channel accept (one-hot or zero, combinational)
//   dout       : cast result
//   dout_valid : dout/dout_ch/warning are valid
//   dout_ready : downstream accept
//   dout_ch    : source channel of dout
//   warning    : 0 ok, 1 positive saturation, 2 negative saturation
//   sat_cnt    : per-channel saturation counters, CNT_WIDTH each
//   sat_clr    : clears all saturation counters
module cast_rr_scheduler #(
  parameter int N_CH       = 4,
  parameter int DIN_WIDTH  = 16,
  parameter int DIN_POINT  = 8,
  parameter int DOUT_WIDTH = 8,
  parameter int DOUT_POINT = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_CH*DIN_WIDTH-1:0]    din,
  input  logic [N_CH-1:0]              din_valid,
  output logic [N_CH-1:0]              din_ready,
  output logic [DOUT_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [$clog2(N_CH)-1:0]      dout_ch,
  output logic [1:0]                   warning,
  output logic [N_CH*CNT_WIDTH-1:0]    sat_cnt,
  input  logic                         sat_clr
);

  localparam int CH_W = $clog2(N_CH);
  // Wide enough to hold the input scaled by 2^DOUT_POINT and any output value.
  localparam int WIDE = DIN_WIDTH + DOUT_WIDTH + DOUT_POINT;

  localparam logic signed [WIDE-1:0] MAX_OUT =
    {{(WIDE-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE-1:0] MIN_OUT =
    {{(WIDE-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic [CH_W-1:0]           last_grant;
  logic [CH_W-1:0]           grant_idx;
  logic                      grant_found;
  logic [CH_W:0]             search_sum;
  logic [CH_W-1:0]           cand;
  logic                      stage_free;
  logic                      xfer;
  logic [DIN_WIDTH-1:0]      sel_din;
  logic signed [WIDE-1:0]    ext;
  logic signed [WIDE-1:0]    aligned;
  logic [DOUT_WIDTH-1:0]     cast_dout;
  logic [1:0]                cast_warn;

  assign stage_free = !dout_valid || dout_ready;

  // Round-robin search starting one past the last granted channel. The sum
  // is one bit wider than the index so non-power-of-two N_CH wraps correctly.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_sum  = '0;
    cand        = '0;
    for (int k = 1; k <= N_CH; k++) begin
      search_sum = {1'b0, last_grant} + (CH_W+1)'(k);
      if (search_sum >= (CH_W+1)'(N_CH))
        search_sum = search_sum - (CH_W+1)'(N_CH);
      cand = search_sum[CH_W-1:0];
      if (!grant_found && din_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    din_ready = '0;
    if (grant_found && stage_free && !rst)
      din_ready[grant_idx] = 1'b1;
  end

  assign xfer    = |din_ready;
  assign sel_din = din[grant_idx*DIN_WIDTH +: DIN_WIDTH];

  // Scaling by 2^DOUT_POINT then arithmetic-shifting by DIN_POINT yields
  // floor truncation or zero padding of the fraction in one expression.
  // Overflow can only occur when the output has fewer integer bits.
  always_comb begin
    ext     = {{(WIDE-DIN_WIDTH){sel_din[DIN_WIDTH-1]}}, sel_din};
    aligned = (ext <<< DOUT_POINT) >>> DIN_POINT;
    if (aligned > MAX_OUT) begin
      cast_dout = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
      cast_warn = 2'd1;
    end else if (aligned < MIN_OUT) begin
      cast_dout = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      cast_warn = 2'd2;
    end else begin
      cast_dout = aligned[DOUT_WIDTH-1:0];
      cast_warn = 2'd0;
    end
  end

  // Output register. A held word stays put until accepted; a reset drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_ch    <= '0;
      warning    <= 2'd0;
      last_grant <= CH_W'(N_CH-1);
    end else if (xfer) begin
      dout       <= cast_dout;
      dout_valid <= 1'b1;
      dout_ch    <= grant_idx;
      warning    <= cast_warn;
      last_grant <= grant_idx;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef CAST_SAT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [N_CH];

  // Counters stick at all-ones; a clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      for (int i = 0; i < N_CH; i++)
        cnt_q[i] <= '0;
    end else if (xfer && cast_warn != 2'd0 && cnt_q[grant_idx] != '1) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    sat_cnt = '0;
    for (int i = 0; i < N_CH; i++)
      sat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_cnt        = '0;
`endif

endmodule
